// File: rtl/edge_freq_meter_if.sv
// Measurement bus of edge_freq_meter: enable and measured signal in,
// published window count, overflow flag and synchronised z out.
interface edge_freq_meter_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             z;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_vld;
    logic             ovf;
    logic             z_sync;

    modport master (
        output en,
        output z,
        input  cnt_out,
        input  cnt_vld,
        input  ovf,
        input  z_sync
    );

    modport slave (
        input  en,
        input  z,
        output cnt_out,
        output cnt_vld,
        output ovf,
        output z_sync
    );
endinterface

// File: rtl/edge_freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed window of
// clk cycles and publishes a saturating count once per window.
module edge_freq_meter #(
    parameter int WIN_CYCLES = 1000,
    parameter int CNT_W      = 8
) (
    input logic          clk,
    input logic          rst,
    edge_freq_meter_if.slave bus
);
    localparam int WCNT_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CMAX  = '1;

    logic s1_q;
    logic s2_q;
    logic s3_q;

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic              rovf_q, rovf_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              ovf_q,  ovf_d;
    logic              vld_q,  vld_d;

    logic edge_s;
    logic term_s;
    logic sat_s;

    assign edge_s = s2_q & ~s3_q;
    assign term_s = bus.en && (wcnt_q == WLAST);
    assign sat_s  = (rcnt_q == CMAX);

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.z;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        rovf_d = rovf_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        vld_d  = 1'b0;
        if (!bus.en) begin
            wcnt_d = '0;
            rcnt_d = '0;
            rovf_d = 1'b0;
        end else if (term_s) begin
            // Terminal-cycle edge is folded into the finishing window
            if (sat_s && edge_s) begin
                cnt_d = CMAX;
            end else begin
                cnt_d = rcnt_q + CNT_W'(edge_s);
            end
            ovf_d  = rovf_q | (sat_s & edge_s);
            vld_d  = 1'b1;
            wcnt_d = '0;
            rcnt_d = '0;
            rovf_d = 1'b0;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
            if (edge_s) begin
                if (sat_s) begin
                    rovf_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
            rovf_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            rovf_q <= rovf_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.cnt_out = cnt_q;
    assign bus.cnt_vld = vld_q;
    assign bus.ovf     = ovf_q;
    assign bus.z_sync  = s2_q;
endmodule

// File: tb/tb_edge_freq_meter.sv
// Bench for edge_freq_meter: table of square-wave rates, corner sequences
// and randomized traffic checked against a window-level reference model.
`timescale 1ns/1ps
module tb_edge_freq_meter;
    localparam int WA   = 100;
    localparam int WB   = 1000;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;
    localparam int NCYC = 30000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    edge_freq_meter_if #(.CNT_W(CW)) ia ();
    edge_freq_meter_if #(.CNT_W(CW)) ib ();

    edge_freq_meter #(.WIN_CYCLES(WA), .CNT_W(CW)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    edge_freq_meter #(.WIN_CYCLES(WB), .CNT_W(CW)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: sampled z history per clock, a rise sampled at
    // clock j is credited at clock j+2; windows counted in plain ints.
    bit zs[2][NCYC];
    int pos[2];
    int acc[2];
    int e_cnt[2];
    bit e_ovf[2];
    bit e_vld[2];
    bit e_zs[2];
    int cyc_n = 0;

    function automatic bit zin(input int i);
        return (i == 0) ? ia.z : ib.z;
    endfunction

    function automatic bit enin(input int i);
        return (i == 0) ? ia.en : ib.en;
    endfunction

    function automatic bit vld(input int i);
        return (i == 0) ? ia.cnt_vld : ib.cnt_vld;
    endfunction

    task automatic model_step();
        int k;
        int w;
        int total;
        bit r;
        k = cyc_n;
        if (k >= NCYC) begin
            $display("FAIL model_budget: got %0d, expected %0d", k, NCYC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? WA : WB;
            if (rst) begin
                zs[i][k] = 1'b0;
                if (k >= 1) zs[i][k-1] = 1'b0;
                if (k >= 2) zs[i][k-2] = 1'b0;
                pos[i]   = 0;
                acc[i]   = 0;
                e_cnt[i] = 0;
                e_ovf[i] = 1'b0;
                e_vld[i] = 1'b0;
                e_zs[i]  = 1'b0;
            end else begin
                r = (k >= 3) && zs[i][k-2] && !zs[i][k-3];
                zs[i][k] = zin(i);
                e_zs[i]  = (k >= 1) ? zs[i][k-1] : 1'b0;
                e_vld[i] = 1'b0;
                if (!enin(i)) begin
                    pos[i] = 0;
                    acc[i] = 0;
                end else if (pos[i] == w - 1) begin
                    total    = acc[i] + int'(r);
                    e_cnt[i] = (total > MAXC) ? MAXC : total;
                    e_ovf[i] = (total > MAXC);
                    e_vld[i] = 1'b1;
                    pos[i]   = 0;
                    acc[i]   = 0;
                end else begin
                    acc[i] += int'(r);
                    pos[i]++;
                end
            end
        end
        cyc_n++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("a_vld",   ia.cnt_vld, e_vld[0]);
            chk("a_cnt",   ia.cnt_out, e_cnt[0]);
            chk("a_ovf",   ia.ovf,     e_ovf[0]);
            chk("a_zsync", ia.z_sync,  e_zs[0]);
            chk("b_vld",   ib.cnt_vld, e_vld[1]);
            chk("b_cnt",   ib.cnt_out, e_cnt[1]);
            chk("b_ovf",   ib.ovf,     e_ovf[1]);
            chk("b_zsync", ib.z_sync,  e_zs[1]);
        end
    end

    // z generators: 0 = constant, 1 = square wave, 2 = random toggling
    int zm[2]   = '{0, 0};
    bit zc[2]   = '{1'b0, 1'b0};
    int half[2] = '{5, 5};
    int ph[2]   = '{0, 0};
    bit zv[2]   = '{1'b0, 1'b0};

    initial forever begin
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            case (zm[i])
                0: zv[i] = zc[i];
                1: begin
                    if (ph[i] >= half[i] - 1) begin
                        zv[i] = ~zv[i];
                        ph[i] = 0;
                    end else begin
                        ph[i]++;
                    end
                end
                default: if ($urandom_range(0, 3) == 0) zv[i] = ~zv[i];
            endcase
        end
        ia.z = zv[0];
        ib.z = zv[1];
    end

    task automatic wait_vld(input int i, input int budget, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (vld(i)) done = 1'b1;
        end
        if (!done) n = -1;
    endtask

    typedef struct {
        int half;
        int cnt;
        bit ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        int nv;
        int first;
        tbl[0] = '{5, 10, 1'b0};
        tbl[1] = '{10, 5, 1'b0};
        tbl[2] = '{1, 50, 1'b0};
        tbl[3] = '{2, 25, 1'b0};
        tbl[4] = '{25, 2, 1'b0};
        tbl[5] = '{50, 1, 1'b0};

        ia.en = 1'b0;
        ia.z  = 1'b0;
        ib.en = 1'b0;
        ib.z  = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_cnt", ia.cnt_out, 0);
        chk("rst_vld", ia.cnt_vld, 0);
        chk("rst_ovf", ia.ovf, 0);
        chk("rst_zsync", ia.z_sync, 0);
        rst = 1'b0;

        ia.en = 1'b1;
        zm[0] = 1;
        for (int v = 0; v < 6; v++) begin
            half[0] = tbl[v].half;
            for (int j = 0; j < 3; j++) begin
                wait_vld(0, WA + 10, n);
                chk("tbl_vld_seen", (n > 0), 1);
            end
            chk("tbl_cnt", ia.cnt_out, tbl[v].cnt);
            chk("tbl_ovf", ia.ovf, tbl[v].ovf);
        end

        zm[0] = 0;
        zc[0] = 1'b0;
        ia.en = 1'b0;
        repeat (10) @(negedge clk);
        ia.en = 1'b1;
        repeat (97) @(negedge clk);
        zc[0] = 1'b1;
        wait_vld(0, 10, n);
        chk("term_lat", n, 3);
        chk("term_cnt", ia.cnt_out, 1);
        wait_vld(0, WA + 10, n);
        chk("term_next_lat", n, WA);
        chk("term_next_cnt", ia.cnt_out, 0);

        zm[0]   = 1;
        half[0] = 5;
        ia.en   = 1'b0;
        repeat (5) @(negedge clk);
        ia.en = 1'b1;
        nv = 0;
        repeat (50) begin
            @(negedge clk);
            if (ia.cnt_vld) nv++;
        end
        ia.en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ia.cnt_vld) nv++;
        end
        chk("abort_vld", nv, 0);
        ia.en = 1'b1;
        wait_vld(0, WA + 20, n);
        chk("reen_lat", n, WA);
        chk("reen_cnt", ia.cnt_out, 10);

        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cnt", ia.cnt_out, 0);
        chk("mrst_vld", ia.cnt_vld, 0);
        chk("mrst_ovf", ia.ovf, 0);
        chk("mrst_zsync", ia.z_sync, 0);
        rst = 1'b0;
        wait_vld(0, WA + 20, n);
        chk("mrst_lat", n, WA);

        zm[0] = 0;
        zc[0] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wait_vld(0, WA + 20, n);
        chk("zhigh_lat", n, WA);
        chk("zhigh_cnt", ia.cnt_out, 1);

        zm[1]   = 1;
        half[1] = 1;
        ib.en   = 1'b1;
        for (int j = 0; j < 2; j++) begin
            wait_vld(1, WB + 10, n);
            chk("sat_vld_seen", (n > 0), 1);
        end
        chk("sat_cnt", ib.cnt_out, MAXC);
        chk("sat_ovf", ib.ovf, 1);
        zm[1] = 0;
        zc[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            wait_vld(1, WB + 10, n);
            chk("stop_vld_seen", (n > 0), 1);
        end
        chk("stop_cnt", ib.cnt_out, 0);
        chk("stop_ovf", ib.ovf, 0);

        zm[0] = 2;
        zm[1] = 2;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) ia.en = ~ia.en;
            if ($urandom_range(0, 599) == 0) ib.en = ~ib.en;
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
